// File: rtl/rf_issue_ctrl_if.sv
// Fetch-side and backend-side signal bundle of the RF issue controller.
// The slave modport is the controller; the master modport is the fetch/backend driver.
interface rf_issue_ctrl_if #(
  parameter int INSTR_W   = 32,
  parameter int NUM_UNITS = 3,
  parameter int DEPTH     = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                 fe_valid;
  logic [INSTR_W-1:0]   fe_instr;
  logic [NUM_UNITS-1:0] fe_unit_req;
  logic                 fe_load;
  logic                 fe_ready;
  logic [NUM_UNITS-1:0] unit_busy;
  logic                 mem_stall;
  logic                 exception_start;
  logic                 rf_valid;
  logic [INSTR_W-1:0]   rf_instr;
  logic [NUM_UNITS-1:0] rf_unit_req;
  logic                 rf_stall;
  logic                 rf_recover;
  logic                 rf_clear;
  logic [OCC_W-1:0]     rf_occupancy;

  modport master (
    output fe_valid, fe_instr, fe_unit_req, fe_load, unit_busy, mem_stall, exception_start,
    input  fe_ready, rf_valid, rf_instr, rf_unit_req, rf_stall, rf_recover, rf_clear, rf_occupancy
  );

  modport slave (
    input  fe_valid, fe_instr, fe_unit_req, fe_load, unit_busy, mem_stall, exception_start,
    output fe_ready, rf_valid, rf_instr, rf_unit_req, rf_stall, rf_recover, rf_clear, rf_occupancy
  );
endinterface

// File: rtl/rf_issue_ctrl.sv
// RF stage controller: DEPTH-entry hold queue issuing to busy-gated backend units,
// with a load-use interlock and exception flush. Issue is 1 cycle after accept at minimum.
module rf_issue_ctrl #(
  parameter int INSTR_W    = 32,
  parameter int DEPTH      = 2,
  parameter int NUM_UNITS  = 3,
  parameter int LOAD_DELAY = 1
) (
  input  logic clk,
  input  logic rst_n,
  rf_issue_ctrl_if.slave rf_if
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int LC_W  = (LOAD_DELAY > 0) ? $clog2(LOAD_DELAY + 1) : 1;

  typedef struct packed {
    logic [INSTR_W-1:0]   instr;
    logic [NUM_UNITS-1:0] req;
    logic                 load;
  } entry_t;

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_FLUSH} state_t;

  state_t           r_state, w_state_nxt;
  entry_t           r_q [DEPTH];
  logic [DEPTH-1:0] r_held;
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [LC_W-1:0]  r_load_cnt;

  entry_t w_head;
  logic   w_run, w_flush_req, w_head_vld, w_blocked, w_full, w_issue, w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_head      = r_q[r_rd_ptr];
  assign w_run       = (r_state == ST_RUN);
  assign w_flush_req = rf_if.exception_start & (r_state != ST_START);
  assign w_head_vld  = (r_occ != '0);
  assign w_full      = (r_occ == OCC_W'(DEPTH));
  assign w_blocked   = rf_if.mem_stall | (|(w_head.req & rf_if.unit_busy)) | (r_load_cnt != '0);
  assign w_issue     = w_run & ~rf_if.exception_start & w_head_vld & ~w_blocked;
  // A full queue still accepts when the head leaves in the same cycle.
  assign rf_if.fe_ready = w_run & ~rf_if.exception_start & (~w_full | w_issue);
  assign w_push      = rf_if.fe_valid & rf_if.fe_ready;

  assign rf_if.rf_valid     = w_issue;
  assign rf_if.rf_instr     = w_head.instr;
  assign rf_if.rf_unit_req  = w_head.req;
  assign rf_if.rf_stall     = w_run & w_head_vld & w_blocked;
  assign rf_if.rf_recover   = w_issue & r_held[r_rd_ptr];
  assign rf_if.rf_clear     = w_flush_req;
  assign rf_if.rf_occupancy = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_START;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN:   if (rf_if.exception_start) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (!rf_if.exception_start && !rf_if.mem_stall && rf_if.unit_busy == '0)
                  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_held     <= '0;
      r_load_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (w_flush_req) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_held     <= '0;
      r_load_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wr_ptr]    <= '{instr: rf_if.fe_instr, req: rf_if.fe_unit_req, load: rf_if.fe_load};
        r_held[r_wr_ptr] <= 1'b0;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      // A stalled head never shares its slot with the write pointer (queue not full or no push).
      if (w_issue)             r_rd_ptr         <= ptr_inc(r_rd_ptr);
      else if (rf_if.rf_stall) r_held[r_rd_ptr] <= 1'b1;

      case ({w_push, w_issue})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_issue && w_head.load) r_load_cnt <= LC_W'(LOAD_DELAY);
      else if (r_load_cnt != '0)  r_load_cnt <= r_load_cnt - LC_W'(1);
    end
  end
endmodule

// File: tb/tb_rf_issue_ctrl.sv
// Bench for rf_issue_ctrl (DEPTH=3, LOAD_DELAY=2): directed cycle checks plus an
// in-order scoreboard filled on accept and drained on issue/flush.
module tb_rf_issue_ctrl;
  localparam int INSTR_W = 32;
  localparam int NU      = 3;
  localparam int DEPTH   = 3;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [NU-1:0]      req;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rf_issue_ctrl_if #(.INSTR_W(INSTR_W), .NUM_UNITS(NU), .DEPTH(DEPTH)) rf_if ();

  rf_issue_ctrl #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .NUM_UNITS(NU), .LOAD_DELAY(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf_if (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compares issue order and occupancy against accepted-but-unissued work.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
      end else begin
        chk("occ_vs_sb", 32'(rf_if.rf_occupancy), 32'(sb.size()));
        if (rf_if.rf_clear) begin
          sb.delete();
        end else begin
          if (rf_if.rf_valid) begin
            if (sb.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
            else begin
              exp_t e;
              e = sb.pop_front();
              chk("order_instr", rf_if.rf_instr, e.instr);
              chk("order_req", 32'(rf_if.rf_unit_req), 32'(e.req));
            end
          end
          if (rf_if.fe_valid && rf_if.fe_ready)
            sb.push_back('{rf_if.fe_instr, rf_if.fe_unit_req});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq;
    logic        acc;
    rst_n = 1'b0;
    rf_if.fe_valid = 1'b1;
    rf_if.fe_instr = 32'h100;
    rf_if.fe_unit_req = '0;
    rf_if.fe_load = 1'b0;
    rf_if.unit_busy = '0;
    rf_if.mem_stall = 1'b0;
    rf_if.exception_start = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_fe_ready", 32'(rf_if.fe_ready), 0);
    chk("rst_valid", 32'(rf_if.rf_valid), 0);
    chk("rst_instr", rf_if.rf_instr, 0);
    chk("rst_occ", 32'(rf_if.rf_occupancy), 0);
    chk("rst_clear_stall", 32'({rf_if.rf_clear, rf_if.rf_stall, rf_if.rf_recover}), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_fe_ready", 32'(rf_if.fe_ready), 0);
    tick();

    // Continuous streaming, no busy: one issue per cycle, occupancy 1
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_ready", 32'(rf_if.fe_ready), 1);
      chk("stream_valid", 32'(rf_if.rf_valid), (i > 0) ? 32'd1 : 32'd0);
      chk("stream_occ", 32'(rf_if.rf_occupancy), (i > 0) ? 32'd1 : 32'd0);
      tick();
      rf_if.fe_instr = 32'h101 + 32'(i);
    end
    rf_if.fe_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", rf_if.rf_instr, 32'h105);
    tick();
    @(negedge clk);
    chk("stream_idle", 32'(rf_if.rf_valid), 0);
    tick();

    // Unit-busy stall fills the queue, then recovers
    rf_if.unit_busy = 3'b010;
    rf_if.fe_valid = 1'b1;
    rf_if.fe_instr = 32'h200;
    rf_if.fe_unit_req = 3'b010;
    @(negedge clk);
    chk("empty_no_stall", 32'(rf_if.rf_stall), 0);
    tick();
    rf_if.fe_unit_req = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      rf_if.fe_instr = 32'h200 + 32'(i);
      @(negedge clk);
      chk("busy_stall", 32'(rf_if.rf_stall), 1);
      chk("busy_novalid", 32'(rf_if.rf_valid), 0);
      chk("busy_ready", 32'(rf_if.fe_ready), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) tick();
      else begin
        @(posedge clk); #1;
        rf_if.fe_instr = 32'h203;
      end
    end
    rf_if.unit_busy = 3'b000;
    @(negedge clk);
    chk("recover_valid", 32'(rf_if.rf_valid), 1);
    chk("recover_flag", 32'(rf_if.rf_recover), 1);
    chk("recover_ready", 32'(rf_if.fe_ready), 1);
    chk("recover_full", 32'(rf_if.rf_occupancy), 3);
    tick();
    rf_if.fe_valid = 1'b0;
    @(negedge clk);
    chk("next_no_recover", 32'({rf_if.rf_valid, rf_if.rf_recover}), 32'b10);
    repeat (3) tick();

    // Load-use interlock: LOAD_DELAY=2 gives a 3-cycle issue gap
    rf_if.fe_valid = 1'b1;
    rf_if.fe_instr = 32'h300;
    rf_if.fe_load = 1'b1;
    @(negedge clk);
    tick();
    rf_if.fe_instr = 32'h301;
    rf_if.fe_load = 1'b0;
    @(negedge clk);
    chk("load_issue", 32'(rf_if.rf_valid), 1);
    tick();
    rf_if.fe_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("load_stall", 32'({rf_if.rf_stall, rf_if.rf_valid}), 32'b10);
      tick();
    end
    @(negedge clk);
    chk("load_dep_issue", 32'(rf_if.rf_valid), 1);
    chk("load_dep_recover", 32'(rf_if.rf_recover), 1);
    repeat (2) tick();

    // Exception with full queue and busy unit
    rf_if.unit_busy = 3'b001;
    rf_if.fe_valid = 1'b1;
    rf_if.fe_unit_req = 3'b001;
    rf_if.fe_instr = 32'h400;
    @(negedge clk);
    tick();
    rf_if.fe_unit_req = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      rf_if.fe_instr = 32'h400 + 32'(i);
      @(negedge clk);
      tick();
    end
    chk("exc_full_occ", 32'(rf_if.rf_occupancy), 3);
    rf_if.exception_start = 1'b1;
    @(negedge clk);
    chk("exc_clear", 32'(rf_if.rf_clear), 1);
    chk("exc_no_issue", 32'({rf_if.rf_valid, rf_if.fe_ready}), 0);
    tick();
    rf_if.exception_start = 1'b0;
    @(negedge clk);
    chk("exc_occ0", 32'(rf_if.rf_occupancy), 0);
    chk("exc_clear_once", 32'(rf_if.rf_clear), 0);
    chk("flush_hold", 32'(rf_if.fe_ready), 0);
    tick();
    @(negedge clk);
    chk("flush_hold2", 32'(rf_if.fe_ready), 0);
    tick();
    rf_if.unit_busy = 3'b000;
    @(negedge clk);
    chk("flush_exit_edge", 32'(rf_if.fe_ready), 0);
    tick();
    @(negedge clk);
    chk("flush_run_ready", 32'(rf_if.fe_ready), 1);
    tick();
    rf_if.fe_valid = 1'b0;
    @(negedge clk);
    chk("flush_post_issue", rf_if.rf_instr, 32'h403);
    chk("flush_post_valid", 32'(rf_if.rf_valid), 1);
    tick();

    // Exception over an issuable head, then a second one inside FLUSH
    rf_if.fe_valid = 1'b1;
    rf_if.fe_instr = 32'h500;
    @(negedge clk);
    tick();
    rf_if.fe_valid = 1'b0;
    rf_if.exception_start = 1'b1;
    @(negedge clk);
    chk("exc2_no_valid", 32'(rf_if.rf_valid), 0);
    chk("exc2_clear", 32'(rf_if.rf_clear), 1);
    tick();
    rf_if.exception_start = 1'b0;
    rf_if.mem_stall = 1'b1;
    @(negedge clk);
    chk("exc2_gap", 32'(rf_if.rf_clear), 0);
    tick();
    rf_if.exception_start = 1'b1;
    @(negedge clk);
    chk("exc2_second_clear", 32'(rf_if.rf_clear), 1);
    tick();
    rf_if.exception_start = 1'b0;
    rf_if.mem_stall = 1'b0;
    @(negedge clk);
    chk("exc2_still_flush", 32'(rf_if.fe_ready), 0);
    tick();
    @(negedge clk);
    chk("exc2_run", 32'(rf_if.fe_ready), 1);
    tick();

    // Random push/pop interleaving with random busy, mem stall and loads
    seq = 32'h600;
    rf_if.fe_instr = seq;
    rf_if.fe_unit_req = 3'($urandom_range(0, 7));
    rf_if.fe_load = 1'($urandom_range(0, 1));
    for (int c = 0; c < 70; c++) begin
      rf_if.fe_valid = ($urandom_range(0, 3) != 0);
      rf_if.unit_busy = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rf_if.mem_stall = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      acc = rf_if.fe_valid & rf_if.fe_ready;
      chk("rand_occ_max", 32'(rf_if.rf_occupancy <= 2'(DEPTH)), 1);
      tick();
      if (acc) begin
        seq = seq + 1;
        rf_if.fe_instr = seq;
        rf_if.fe_unit_req = 3'($urandom_range(0, 7));
        rf_if.fe_load = 1'($urandom_range(0, 1));
      end
    end
    rf_if.fe_valid = 1'b0;
    rf_if.unit_busy = '0;
    rf_if.mem_stall = 1'b0;
    repeat (14) tick();
    chk("rand_drained", 32'(sb.size()), 0);
    chk("rand_enough_pushes", 32'((seq - 32'h600) >= 10), 1);

    // Asynchronous reset mid-operation drops queued work without rf_clear
    rf_if.unit_busy = 3'b010;
    rf_if.fe_valid = 1'b1;
    rf_if.fe_unit_req = 3'b010;
    rf_if.fe_instr = 32'h700;
    @(negedge clk);
    tick();
    rf_if.fe_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", 32'(rf_if.rf_stall), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_occ", 32'(rf_if.rf_occupancy), 0);
    chk("mid_rst_outs", 32'({rf_if.rf_clear, rf_if.rf_stall, rf_if.fe_ready, rf_if.rf_valid}), 0);
    chk("mid_rst_instr", rf_if.rf_instr, 0);
    tick();
    rst_n = 1'b1;
    rf_if.unit_busy = '0;
    @(negedge clk);
    chk("post_rst_start", 32'(rf_if.fe_ready), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
